// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bp_pkg
//  Description : Shared types and constants for the branch update tracker.
//                The in-flight entry records one prediction issued at fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

    // Default PC / target width
    localparam int PC_W_DEFAULT = 32;

    // Size of a branch instruction in bytes (fall-through increment)
    localparam int C_BR_INSN_BYTES = 4;

    // One in-flight prediction
    typedef struct packed {
        logic [PC_W_DEFAULT-1:0] pc;
        logic                    taken;
        logic [PC_W_DEFAULT-1:0] target;
    } bp_entry_t;

endpackage
`default_nettype wire

// File: rtl/bp_inflight_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : bp_inflight_fifo
//  Description : In-order queue of in-flight predictions. Head entry is
//                presented combinationally; synchronous clear has priority
//                over push and pop in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module bp_inflight_fifo
    import bp_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = bp_entry_t
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  T                           wdata,
    output T                           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    T                 r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_push;
    logic             w_pop;

    assign full  = (r_count == CNT_W'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign rdata = r_mem[r_rd_ptr];

    // Pushes are refused when full and pops when empty, so the pointers
    // never overrun each other.
    assign w_push = push && !full;
    assign w_pop  = pop  && !empty;

    // Entry storage: data only, no reset needed since count gates validity
    always_ff @(posedge CLK) begin
        if (w_push && !clear) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally (DEPTH = 2^n)
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_update_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : branch_update_tracker
//  Description : Tracks predictions issued at fetch, pairs them in order with
//                outcomes resolved in execute, trains the predictor, detects
//                mispredictions and squashes younger wrong-path entries.
//                Optional statistics counters enabled by macro BP_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_update_tracker
    import bp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = PC_W_DEFAULT
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     pred_valid,
    output logic                     pred_ready,
    input  logic                     pred_taken,
    input  logic [PC_W-1:0]          pred_target,
    input  logic [PC_W-1:0]          pred_pc,
    input  logic                     resolve_valid,
    input  logic                     resolve_taken,
    input  logic [PC_W-1:0]          resolve_target,
    input  logic                     ext_flush,
    output logic                     update_predictor,
    output logic                     branch_result,
    output logic [PC_W-1:0]          update_pc,
    output logic                     mispredict,
    output logic [PC_W-1:0]          redirect_pc,
    output logic                     resolve_err,
    output logic [$clog2(DEPTH):0]   inflight_count
`ifdef BP_STATS_EN
    ,
    output logic [31:0]              branch_count,
    output logic [31:0]              mispredict_count
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Entry layout matches bp_entry_t but follows this instance's PC_W
    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            taken;
        logic [PC_W-1:0] target;
    } entry_t;

    entry_t           w_wdata;
    entry_t           w_head;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    logic             w_pop;
    logic             w_mispredict;
    logic             w_clear;
    logic             w_push;
    logic [PC_W-1:0]  w_correct_pc;

    assign w_wdata = '{pc: pred_pc, taken: pred_taken, target: pred_target};

    // A flush discards the resolve outright; otherwise a resolve pops only
    // when there is something to pop.
    assign w_pop = resolve_valid && !w_empty && !ext_flush;

    assign w_mispredict = w_pop &&
                          ((resolve_taken != w_head.taken) ||
                           (resolve_taken && (resolve_target != w_head.target)));

    // Everything younger than a mispredicted head is wrong-path, so the whole
    // queue goes, including any same-cycle push.
    assign w_clear = ext_flush || w_mispredict;
    assign w_push  = pred_valid && !w_full && !w_clear;

    assign w_correct_pc = resolve_taken ? resolve_target
                                        : (w_head.pc + PC_W'(C_BR_INSN_BYTES));

    assign pred_ready     = !w_full;
    assign inflight_count = w_count;

    bp_inflight_fifo #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .CLK   (CLK),
        .nRST  (nRST),
        .clear (w_clear),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (w_wdata),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    // Training and redirect outputs: pulses for one cycle, PCs hold
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            update_predictor <= 1'b0;
            branch_result    <= 1'b0;
            update_pc        <= '0;
            mispredict       <= 1'b0;
            redirect_pc      <= '0;
        end else begin
            update_predictor <= w_pop;
            branch_result    <= w_pop && resolve_taken;
            mispredict       <= w_mispredict;
            if (w_pop) begin
                update_pc <= w_head.pc;
            end
            if (w_mispredict) begin
                redirect_pc <= w_correct_pc;
            end
        end
    end

    // Sticky error: execute resolved a branch nobody predicted
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            resolve_err <= 1'b0;
        end else if (resolve_valid && w_empty && !ext_flush) begin
            resolve_err <= 1'b1;
        end
    end

`ifdef BP_STATS_EN
    // Saturating statistics, cleared only by reset
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (w_pop && (branch_count != '1)) begin
                branch_count <= branch_count + 32'd1;
            end
            if (w_mispredict && (mispredict_count != '1)) begin
                mispredict_count <= mispredict_count + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_update_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_update_tracker
//  Description : Directed self-checking bench for branch_update_tracker.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_update_tracker;

    localparam int DEPTH = 4;
    localparam int PC_W  = 32;

    logic            CLK;
    logic            nRST;
    logic            pred_valid;
    logic            pred_ready;
    logic            pred_taken;
    logic [PC_W-1:0] pred_target;
    logic [PC_W-1:0] pred_pc;
    logic            resolve_valid;
    logic            resolve_taken;
    logic [PC_W-1:0] resolve_target;
    logic            ext_flush;
    logic            update_predictor;
    logic            branch_result;
    logic [PC_W-1:0] update_pc;
    logic            mispredict;
    logic [PC_W-1:0] redirect_pc;
    logic            resolve_err;
    logic [2:0]      inflight_count;
`ifdef BP_STATS_EN
    logic [31:0]     branch_count;
    logic [31:0]     mispredict_count;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    branch_update_tracker #(
        .DEPTH (DEPTH),
        .PC_W  (PC_W)
    ) dut (
        .CLK              (CLK),
        .nRST             (nRST),
        .pred_valid       (pred_valid),
        .pred_ready       (pred_ready),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .pred_pc          (pred_pc),
        .resolve_valid    (resolve_valid),
        .resolve_taken    (resolve_taken),
        .resolve_target   (resolve_target),
        .ext_flush        (ext_flush),
        .update_predictor (update_predictor),
        .branch_result    (branch_result),
        .update_pc        (update_pc),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .resolve_err      (resolve_err),
        .inflight_count   (inflight_count)
`ifdef BP_STATS_EN
        ,
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; return 1 time unit after the edge
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        pred_valid  = 1'b1;
        pred_pc     = pc;
        pred_taken  = tk;
        pred_target = tgt;
        tick();
        pred_valid  = 1'b0;
    endtask

    initial begin
        nRST           = 1'b0;
        pred_valid     = 1'b0;
        pred_taken     = 1'b0;
        pred_target    = '0;
        pred_pc        = '0;
        resolve_valid  = 1'b0;
        resolve_taken  = 1'b0;
        resolve_target = '0;
        ext_flush      = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_ready",   32'(pred_ready),       32'd1);
        check("rst_count",   32'(inflight_count),   32'd0);
        check("rst_update",  32'(update_predictor), 32'd0);
        check("rst_result",  32'(branch_result),    32'd0);
        check("rst_mispred", 32'(mispredict),       32'd0);
        check("rst_err",     32'(resolve_err),      32'd0);
        check("rst_upc",     update_pc,             32'h0);
        check("rst_rpc",     redirect_pc,           32'h0);
        nRST = 1'b1;
        tick();

        // Correctly predicted taken branch trains
        push(32'h100, 1'b1, 32'h200);
        check("t1_count", 32'(inflight_count), 32'd1);
        resolve_valid = 1'b1; resolve_taken = 1'b1; resolve_target = 32'h200;
        tick();
        resolve_valid = 1'b0;
        check("t1_update",  32'(update_predictor), 32'd1);
        check("t1_result",  32'(branch_result),    32'd1);
        check("t1_upc",     update_pc,             32'h100);
        check("t1_mispred", 32'(mispredict),       32'd0);
        check("t1_count0",  32'(inflight_count),   32'd0);
        tick();
        check("t1_pulse_end", 32'(update_predictor), 32'd0);

        // Direction mispredict
        push(32'h100, 1'b0, 32'h0);
        resolve_valid = 1'b1; resolve_taken = 1'b1; resolve_target = 32'h300;
        tick();
        resolve_valid = 1'b0;
        check("t2_mispred", 32'(mispredict),       32'd1);
        check("t2_rpc",     redirect_pc,           32'h300);
        check("t2_count",   32'(inflight_count),   32'd0);
        check("t2_update",  32'(update_predictor), 32'd1);
        tick();
        check("t2_pulse_end", 32'(mispredict),     32'd0);
        check("t2_rpc_hold",  redirect_pc,         32'h300);

        // Target mispredict squashes younger entries and a same-cycle push
        push(32'h100, 1'b1, 32'h200);
        push(32'h200, 1'b0, 32'h0);
        push(32'h204, 1'b0, 32'h0);
        check("t3_count3", 32'(inflight_count), 32'd3);
        resolve_valid = 1'b1; resolve_taken = 1'b1; resolve_target = 32'h240;
        pred_valid = 1'b1; pred_pc = 32'h300; pred_taken = 1'b0;
        tick();
        pred_valid = 1'b0;
        resolve_valid = 1'b0;
        check("t3_mispred", 32'(mispredict),     32'd1);
        check("t3_rpc",     redirect_pc,         32'h240);
        check("t3_upc",     update_pc,           32'h100);
        check("t3_count0",  32'(inflight_count), 32'd0);
        resolve_valid = 1'b1; resolve_taken = 1'b0;
        tick();
        resolve_valid = 1'b0;
        check("t3_err",        32'(resolve_err),      32'd1);
        check("t3_err_notrain", 32'(update_predictor), 32'd0);
        tick();
        check("t3_err_sticky", 32'(resolve_err), 32'd1);

        // Fill to DEPTH, overflow push ignored, drain in order
        push(32'h400, 1'b0, 32'h0);
        push(32'h404, 1'b0, 32'h0);
        push(32'h408, 1'b0, 32'h0);
        push(32'h40C, 1'b0, 32'h0);
        check("t4_ready0", 32'(pred_ready),     32'd0);
        check("t4_count4", 32'(inflight_count), 32'd4);
        push(32'h500, 1'b1, 32'h600);
        check("t4_count_ovf", 32'(inflight_count), 32'd4);
        resolve_valid = 1'b1; resolve_taken = 1'b0;
        tick();
        check("t4_upc0", update_pc, 32'h400);
        check("t4_upd0", 32'(update_predictor), 32'd1);
        tick();
        check("t4_upc1", update_pc, 32'h404);
        check("t4_upd1", 32'(update_predictor), 32'd1);
        tick();
        check("t4_upc2", update_pc, 32'h408);
        check("t4_upd2", 32'(update_predictor), 32'd1);
        tick();
        resolve_valid = 1'b0;
        check("t4_upc3",    update_pc, 32'h40C);
        check("t4_upd3",    32'(update_predictor), 32'd1);
        check("t4_mispred", 32'(mispredict),       32'd0);
        check("t4_result",  32'(branch_result),    32'd0);
        check("t4_empty",   32'(inflight_count),   32'd0);
        check("t4_ready1",  32'(pred_ready),       32'd1);

        // Simultaneous push and correct pop keeps occupancy
        push(32'h600, 1'b0, 32'h0);
        pred_valid = 1'b1; pred_pc = 32'h604; pred_taken = 1'b0;
        resolve_valid = 1'b1; resolve_taken = 1'b0;
        tick();
        pred_valid = 1'b0;
        check("t5_count", 32'(inflight_count), 32'd1);
        check("t5_upc",   update_pc,           32'h600);
        tick();
        resolve_valid = 1'b0;
        check("t5_upc2",   update_pc,           32'h604);
        check("t5_count0", 32'(inflight_count), 32'd0);

        // Fall-through PC wraps around the address space
        push(32'hFFFF_FFFC, 1'b1, 32'h1000);
        resolve_valid = 1'b1; resolve_taken = 1'b0;
        tick();
        resolve_valid = 1'b0;
        check("t6_mispred", 32'(mispredict), 32'd1);
        check("t6_rpc",     redirect_pc,     32'h0);
        check("t6_result",  32'(branch_result), 32'd0);

`ifdef BP_STATS_EN
        check("st_br_pre", branch_count,     32'd10);
        check("st_mp_pre", mispredict_count, 32'd3);
`endif

        // External flush drops resolve and queue, no training
        push(32'h700, 1'b1, 32'h800);
        push(32'h800, 1'b0, 32'h0);
        push(32'h804, 1'b0, 32'h0);
        ext_flush = 1'b1; resolve_valid = 1'b1; resolve_taken = 1'b0;
        tick();
        ext_flush = 1'b0; resolve_valid = 1'b0;
        check("t7_update",  32'(update_predictor), 32'd0);
        check("t7_mispred", 32'(mispredict),       32'd0);
        check("t7_count",   32'(inflight_count),   32'd0);
`ifdef BP_STATS_EN
        check("st_br_post", branch_count,     32'd10);
        check("st_mp_post", mispredict_count, 32'd3);
`endif

        // Asynchronous reset mid-operation
        push(32'h900, 1'b0, 32'h0);
        push(32'h904, 1'b0, 32'h0);
        resolve_valid = 1'b1; resolve_taken = 1'b1; resolve_target = 32'hA00;
        @(negedge CLK);
        nRST = 1'b0;
        #1;
        resolve_valid = 1'b0;
        check("t8_count", 32'(inflight_count), 32'd0);
        check("t8_err",   32'(resolve_err),    32'd0);
        check("t8_ready", 32'(pred_ready),     32'd1);
        tick();
        check("t8_update", 32'(update_predictor), 32'd0);
        check("t8_rpc",    redirect_pc,           32'h0);
        nRST = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
